// File: rtl/lite16_lsu.sv
`default_nettype none
// ============================================================================
// Module   : lite16_lsu
// Brief    : LITE-16 load/store unit; forms base+offset addresses, drives the
//            data RAM and returns load data over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module lite16_lsu #(
    parameter int          OFF_W     = 6,
    parameter int          RD_W      = 4,
    parameter int unsigned MEM_WORDS = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [15:0]      req_base,
    input  logic [OFF_W-1:0] req_off,
    input  logic [15:0]      req_wdata,
    input  logic [RD_W-1:0]  req_rd,
    output logic [15:0]      mem_address,
    output logic [15:0]      mem_data_in,
    output logic             mem_store,
    output logic             mem_load,
    input  logic [15:0]      mem_data_out,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [RD_W-1:0]  wb_rd,
    output logic [15:0]      wb_data,
    output logic             fault
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_STORE   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic [15:0]     r_mem_address;
    logic [15:0]     r_mem_data_in;
    logic [RD_W-1:0] r_rd;
    logic [RD_W-1:0] r_wb_rd;
    logic [15:0]     r_wb_data;
    logic            r_fault;

    logic [15:0]     w_off_ext;
    logic [15:0]     w_ea;
    logic            w_accept;
    logic            w_in_range;

    assign w_off_ext  = {{(16-OFF_W){req_off[OFF_W-1]}}, req_off};
    assign w_ea       = req_base + w_off_ext;
    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_in_range = {16'd0, w_ea} < MEM_WORDS;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_in_range) begin
                    w_next = req_store ? S_STORE : S_LOAD;
                end
            end
            S_STORE:   w_next = S_IDLE;
            S_LOAD:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP: begin
                if (wb_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // Address/data registers only move on a legal accept so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mem_address <= 16'd0;
            r_mem_data_in <= 16'd0;
            r_rd          <= '0;
            r_wb_rd       <= '0;
            r_wb_data     <= 16'd0;
            r_fault       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_fault <= w_accept && !w_in_range;
            if (w_accept && w_in_range) begin
                r_mem_address <= w_ea;
                r_rd          <= req_rd;
                if (req_store) begin
                    r_mem_data_in <= req_wdata;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_wb_data <= mem_data_out;
                r_wb_rd   <= r_rd;
            end
        end
    end

    // RAM strobes are gated by rst so an in-flight access aborts in that cycle.
    assign req_ready   = (r_state == S_IDLE);
    assign mem_store   = (r_state == S_STORE) && !rst;
    assign mem_load    = (r_state == S_LOAD) && !rst;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign wb_valid    = (r_state == S_RESP);
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_lite16_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lite16_lsu
// Brief    : Scoreboard bench for lite16_lsu with a small synchronous RAM model.
// Revision : 1.0
// ============================================================================
module tb_lite16_lsu;

    localparam int          OFF_W     = 6;
    localparam int          RD_W      = 4;
    localparam int unsigned MEM_WORDS = 256;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } st_t;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [15:0]     data;
    } wb_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [15:0]      req_base;
    logic [OFF_W-1:0] req_off;
    logic [15:0]      req_wdata;
    logic [RD_W-1:0]  req_rd;
    logic [15:0]      mem_address;
    logic [15:0]      mem_data_in;
    logic             mem_store;
    logic             mem_load;
    logic [15:0]      mem_data_out;
    logic             wb_valid;
    logic             wb_ready;
    logic [RD_W-1:0]  wb_rd;
    logic [15:0]      wb_data;
    logic             fault;

    logic [15:0] ram [0:255];

    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  fault_seen = 0;
    int  fault_exp = 0;
    st_t exp_st[$];
    wb_t exp_wb[$];

    lite16_lsu #(.OFF_W(OFF_W), .RD_W(RD_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_base(req_base), .req_off(req_off), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_store(mem_store), .mem_load(mem_load), .mem_data_out(mem_data_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: write on the store edge, read data appears the cycle after mem_load.
    always @(posedge clk) begin
        if (mem_store) ram[mem_address[7:0]] <= mem_data_in;
        if (mem_load)  mem_data_out <= ram[mem_address[7:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got none expected event", name);
    endtask

    // Monitor: pops expected RAM writes and writeback results as the DUT presents them.
    always @(negedge clk) begin
        st_t es;
        wb_t ew;
        if (mem_store || mem_load) check("mem_exclusive", {63'd0, mem_store && mem_load}, 64'd0);
        if (mem_store) begin
            if (exp_st.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_store: got addr %0h expected no store", mem_address);
            end else begin
                es = exp_st.pop_front();
                check("store_addr", {48'd0, mem_address}, {48'd0, es.addr});
                check("store_data", {48'd0, mem_data_in}, {48'd0, es.data});
            end
        end
        if (wb_valid && wb_ready) begin
            if (exp_wb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_wb: got data %0h expected no result", wb_data);
            end else begin
                ew = exp_wb.pop_front();
                check("wb_rd", {60'd0, wb_rd}, {60'd0, ew.rd});
                check("wb_data", {48'd0, wb_data}, {48'd0, ew.data});
            end
        end
        if (fault) fault_seen++;
    end

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic st, input logic [15:0] base, input logic [OFF_W-1:0] off,
                         input logic [15:0] wd, input logic [RD_W-1:0] rd);
        bit ok;
        req_store = st; req_base = base; req_off = off; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (wb_valid) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("resp_timeout");
        @(posedge clk); #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [55:0] out_vec();
        return {req_ready, mem_store, mem_load, mem_address, mem_data_in,
                wb_valid, wb_rd, wb_data, fault};
    endfunction

    localparam logic [55:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000,
                                         1'b0, 4'h0, 16'h0000, 1'b0};

    initial begin
        int n;
        int cnt_a;
        int cnt_b;
        int cnt_c;
        int prev;
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_base = 16'h0;
        req_off = '0; req_wdata = 16'h0; req_rd = '0; wb_ready = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {8'd0, out_vec()}, {8'd0, RESET_VEC});
        @(posedge clk); #1;

        // Store 0x8686 to word 2, then load it back via base 4, offset -2.
        exp_st.push_back('{addr: 16'h0002, data: 16'h8686});
        issue(1'b1, 16'h0000, 6'd2, 16'h8686, 4'd0);
        @(negedge clk);
        check("store_ready_low", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        check("store_ready_back", {63'd0, req_ready}, 64'd1);
        @(posedge clk); #1;
        exp_wb.push_back('{rd: 4'd3, data: 16'h8686});
        issue(1'b0, 16'h0004, 6'h3E, 16'h0000, 4'd3);
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (wb_valid) begin n = i; break; end
        end
        check("load_latency", 64'(n), 64'd3);
        @(posedge clk); #1;
        step(1);

        // Backpressure: result must stay put while wb_ready is low.
        exp_st.push_back('{addr: 16'h0015, data: 16'hBEEF});
        issue(1'b1, 16'h0010, 6'd5, 16'hBEEF, 4'd0);
        step(1);
        wb_ready = 1'b0;
        issue(1'b0, 16'h0015, 6'd0, 16'h0000, 4'd5);
        step(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold", {44'd0, wb_valid, req_ready, wb_rd, wb_data},
                  {44'd0, 1'b1, 1'b0, 4'd5, 16'hBEEF});
        end
        @(posedge clk); #1;
        exp_wb.push_back('{rd: 4'd5, data: 16'hBEEF});
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release", {62'd0, req_ready, wb_valid}, {62'd0, 1'b1, 1'b0});
        @(posedge clk); #1;

        // Wrap: 0xFFFF + 1 lands on word 0 with a single store cycle.
        exp_st.push_back('{addr: 16'h0000, data: 16'h1234});
        issue(1'b1, 16'hFFFF, 6'd1, 16'h1234, 4'd0);
        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_store) cnt_a++;
        end
        check("wrap_store_cycles", 64'(cnt_a), 64'd1);
        @(posedge clk); #1;
        exp_wb.push_back('{rd: 4'd7, data: 16'h1234});
        issue(1'b0, 16'h0000, 6'd0, 16'h0000, 4'd7);
        wait_resp();
        step(1);

        // Out-of-range load: one fault pulse, no RAM access, no result.
        fault_exp++;
        issue(1'b0, 16'h00FF, 6'd1, 16'h0000, 4'd2);
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) check("fault_ready", {63'd0, req_ready}, 64'd1);
            if (fault) cnt_a++;
            if (mem_load) cnt_b++;
            if (wb_valid) cnt_c++;
        end
        check("fault_pulses", 64'(cnt_a), 64'd1);
        check("fault_no_load", 64'(cnt_b), 64'd0);
        check("fault_no_wb", 64'(cnt_c), 64'd0);
        check("fault_addr_hold", {48'd0, mem_address}, 64'd0);
        @(posedge clk); #1;
        fault_exp++;
        issue(1'b1, 16'h0000, 6'h3F, 16'h5555, 4'd0);
        step(3);

        // Reset during CAPTURE discards the pending load.
        issue(1'b0, 16'h0015, 6'd0, 16'h0000, 4'd9);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_capture_outputs", {8'd0, out_vec()}, {8'd0, RESET_VEC});
        @(posedge clk); #1;
        rst = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_valid) cnt_a++;
        end
        check("rst_no_wb", 64'(cnt_a), 64'd0);
        @(posedge clk); #1;

        // Reset during STORE suppresses the write strobe.
        issue(1'b1, 16'h0030, 6'd0, 16'hDEAD, 4'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_store_gated", {63'd0, mem_store}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1);

        // Back-to-back stores with req_valid held high.
        prev = -1;
        req_valid = 1'b1;
        req_store = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit ok;
            req_base = 16'h0020; req_off = 6'(i); req_wdata = 16'hA0A0 + 16'(i);
            exp_st.push_back('{addr: 16'h0020 + 16'(i), data: 16'hA0A0 + 16'(i)});
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (req_ready) begin ok = 1'b1; break; end
            end
            if (!ok) fail_now("b2b_timeout");
            if (prev >= 0) check("b2b_spacing", 64'(cyc - prev), 64'd2);
            prev = cyc;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        step(4);

        check("store_queue_drained", 64'(exp_st.size()), 64'd0);
        check("wb_queue_drained", 64'(exp_wb.size()), 64'd0);
        check("fault_count", 64'(fault_seen), 64'(fault_exp));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/lite16_lsu.md
Name: lite16_lsu

Overview:
- Load/store unit for LITE-16; sits directly upstream of the data RAM.
- Accepts one memory request at a time from the execute stage and computes the effective address as base + sign-extended offset.
- Drives the RAM's address/data_in/store/load pins.
- For loads, captures the RAM's data_out and delivers it to register writeback over a valid/ready handshake.

Parameters:
- OFF_W, 6: width of signed immediate offset.
- RD_W, 4: width of destination register index.
- MEM_WORDS, 65536: number of implemented RAM words; effective addresses >= MEM_WORDS fault.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  execute stage presents a request.
- req_ready  out  1  LSU can accept a request this cycle.
- req_store  in  1  1 = store, 0 = load.
- req_base  in  16  base register value.
- req_off  in  OFF_W  signed offset.
- req_wdata  in  16  store data.
- req_rd  in  RD_W  load destination register.
- mem_address  out  16  to RAM address.
- mem_data_in  out  16  to RAM data_in.
- mem_store  out  1  to RAM store.
- mem_load  out  1  to RAM load.
- mem_data_out  in  16  from RAM data_out.
- wb_valid  out  1  load result available.
- wb_ready  in  1  writeback accepts result.
- wb_rd  out  RD_W  destination register of result.
- wb_data  out  16  loaded word.
- fault  out  1  one-cycle pulse: out-of-range access dropped.

Behaviour:
- RAM contract: a store is written on the posedge where mem_store=1. A load drives mem_load=1 and mem_address for one cycle; mem_data_out is valid on the following cycle.
- Effective address: EA = req_base + sign_extend(req_off), modulo 2^16. It is computed combinationally and registered on accept.
- Handshake: a transfer occurs when req_valid && req_ready. req_ready=1 only in IDLE; req_* are ignored otherwise.
- State IDLE:
  - On accept with EA >= MEM_WORDS: pulse fault=1 next cycle, no RAM access, stay IDLE.
  - On accept of a store: go to STORE.
  - On accept of a load: go to LOAD.
- State STORE (1 cycle): mem_store=1, mem_address=EA, mem_data_in=wdata; then IDLE.
- State LOAD (1 cycle): mem_load=1, mem_address=EA; then CAPTURE.
- State CAPTURE (1 cycle): register mem_data_out into wb_data and the latched rd into wb_rd; then RESP.
- State RESP: wb_valid=1 with wb_data/wb_rd held stable. When wb_ready=1, go to IDLE; otherwise stay.
- Latency and throughput:
  - Store: RAM write 2 posedges after accept; next accept possible 2 cycles after the previous one.
  - Load: wb_valid asserted 3 cycles after the accept edge.
- mem_store and mem_load are never asserted together and are 0 in every state other than STORE/LOAD.
- Outside STORE/LOAD, mem_address and mem_data_in hold their last values.
- Reset: state=IDLE. req_ready=1, mem_store=0, mem_load=0, mem_address=0, mem_data_in=0, wb_valid=0, wb_rd=0, wb_data=0, fault=0.
- Reset asserted mid-operation aborts immediately:
  - A store in STORE that coincides with rst is not issued (mem_store forced 0 that cycle).
  - A pending load result is discarded.
- Wrap-around: base 0xFFFF + offset 1 gives EA 0x0000 (legal); base 0x0000 + offset -1 gives 0xFFFF.

Test Plan:
- Store then load: store base=0x0000, off=2, wdata=0x8686 → RAM word 2 = 0x8686. Then load base=0x0004, off=-2, rd=3 → wb_valid 3 cycles after accept, wb_data=0x8686, wb_rd=3.
- Backpressure: load with wb_ready=0 for 4 cycles → wb_valid/wb_data/wb_rd stable, req_ready=0 throughout; wb_ready=1 → IDLE next cycle, req_ready=1.
- Wrap: store base=0xFFFF, off=1, wdata=0x1234 → mem_address=0x0000 with mem_store=1 for exactly one cycle.
- Fault: MEM_WORDS=256, load base=0x00FF, off=1 → fault pulse one cycle, mem_load never asserted, wb_valid stays 0.
- Reset mid-load: rst asserted in CAPTURE → next cycle all outputs at reset values, wb_valid never asserted for that request.
- Back-to-back stores with req_valid held high → accepts every 2 cycles; mem_store and mem_load never both 1.
